// File: rtl/seq_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_arb_pkg : shared widths and types for the 5-input RR arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_arb_pkg;

    localparam int NUM_IN = 5;
    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [DATA_W-1:0] data_t;

    // Index 'off' positions above 'base', wrapping modulo NUM_IN.
    function automatic sel_t rr_idx(input sel_t base, input sel_t off);
        logic [SEL_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (SEL_W+1)'(NUM_IN)) begin
            sum = sum - (SEL_W+1)'(NUM_IN);
        end
        return sum[SEL_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_rr_arb_4b_5to1_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_rr_arb_4b_5to1_if : requester and output handshake bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seq_rr_arb_4b_5to1_if;
    import seq_arb_pkg::*;

    logic [NUM_IN-1:0] in_val;
    logic [NUM_IN-1:0] in_rdy;
    data_t             in0;
    data_t             in1;
    data_t             in2;
    data_t             in3;
    data_t             in4;
    logic              out_val;
    logic              out_rdy;
    data_t             out;
    sel_t              out_src;

    modport slave (
        input  in_val, in0, in1, in2, in3, in4, out_rdy,
        output in_rdy, out_val, out, out_src
    );

    modport master (
        output in_val, in0, in1, in2, in3, in4, out_rdy,
        input  in_rdy, out_val, out, out_src
    );

endinterface
`default_nettype wire

// File: rtl/seq_rr_arb_4b_5to1_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_4b_5to1 : combinational 5-to-1 mux, out-of-range select gives 0  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mux_4b_5to1
    import seq_arb_pkg::*;
(
    input  wire sel_t  sel_i,
    input  wire data_t in0_i,
    input  wire data_t in1_i,
    input  wire data_t in2_i,
    input  wire data_t in3_i,
    input  wire data_t in4_i,
    output data_t      out_o
);

    always_comb begin
        out_o = '0;
        case (sel_i)
            3'd0:    out_o = in0_i;
            3'd1:    out_o = in1_i;
            3'd2:    out_o = in2_i;
            3'd3:    out_o = in3_i;
            3'd4:    out_o = in4_i;
            default: out_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_rr_arb_4b_5to1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_rr_arb_4b_5to1 : round-robin arbiter with 1-entry output buffer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_rr_arb_4b_5to1
    import seq_arb_pkg::*;
(
    input  wire                     clk,
    input  wire                     reset,
    seq_rr_arb_4b_5to1_if.slave     arb_if
);

    sel_t  ptr_q,     ptr_d;
    logic  out_val_q, out_val_d;
    data_t out_q,     out_d;
    sel_t  out_src_q, out_src_d;

    logic  w_gnt_vld;
    sel_t  w_gnt;
    sel_t  w_idx;
    sel_t  w_sel;
    logic  w_can_accept;
    logic  w_accept;
    data_t w_mux_out;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int k = NUM_IN-1; k >= 0; k--) begin
            w_idx = rr_idx(ptr_q, SEL_W'(k));
            if (arb_if.in_val[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    assign w_can_accept = !out_val_q || arb_if.out_rdy;
    assign w_accept     = w_gnt_vld && w_can_accept && reset;
    assign w_sel        = w_gnt_vld ? w_gnt : '0;

    assign arb_if.in_rdy = w_accept ? (NUM_IN'(1) << w_gnt) : '0;

    mux_4b_5to1 u_mux (
        .sel_i (w_sel),
        .in0_i (arb_if.in0),
        .in1_i (arb_if.in1),
        .in2_i (arb_if.in2),
        .in3_i (arb_if.in3),
        .in4_i (arb_if.in4),
        .out_o (w_mux_out)
    );

    always_comb begin
        ptr_d     = ptr_q;
        out_val_d = out_val_q;
        out_d     = out_q;
        out_src_d = out_src_q;
        if (w_accept) begin
            out_d     = w_mux_out;
            out_src_d = w_gnt;
            out_val_d = 1'b1;
            ptr_d     = (w_gnt == SEL_W'(NUM_IN-1)) ? '0 : w_gnt + 1'b1;
        end else if (out_val_q && arb_if.out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            out_val_q <= 1'b0;
            out_q     <= '0;
            out_src_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            out_val_q <= out_val_d;
            out_q     <= out_d;
            out_src_q <= out_src_d;
        end
    end

    assign arb_if.out_val = out_val_q;
    assign arb_if.out     = out_q;
    assign arb_if.out_src = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_rr_arb_4b_5to1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_rr_arb_4b_5to1 : scoreboard bench for the round-robin arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seq_rr_arb_4b_5to1;
    import seq_arb_pkg::*;

    typedef struct packed {
        sel_t  src;
        data_t data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    seq_rr_arb_4b_5to1_if u_if ();

    seq_rr_arb_4b_5to1 u_dut (
        .clk    (clk),
        .reset  (reset),
        .arb_if (u_if)
    );

    always #5 clk = ~clk;

    task automatic sb_pop(output exp_t e, output bit ok);
        ok = (sb_q.size() != 0);
        e  = ok ? sb_q.pop_front() : '0;
    endtask

    task automatic set_data(input data_t d0, d1, d2, d3, d4);
        u_if.in0 = d0; u_if.in1 = d1; u_if.in2 = d2; u_if.in3 = d3; u_if.in4 = d4;
    endtask

    task automatic test_reset();
        u_if.in_val  = 5'b11111;
        u_if.out_rdy = 1'b1;
        set_data(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        #1 reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks += 4;
            if (u_if.out_val !== 1'b0) begin failures++; $display("FAIL rst_out_val got=%b exp=0", u_if.out_val); end
            if (u_if.out !== 4'h0) begin failures++; $display("FAIL rst_out got=%h exp=0", u_if.out); end
            if (u_if.out_src !== 3'd0) begin failures++; $display("FAIL rst_out_src got=%0d exp=0", u_if.out_src); end
            if (u_if.in_rdy !== 5'b00000) begin failures++; $display("FAIL rst_in_rdy got=%b exp=00000", u_if.in_rdy); end
        end
        u_if.in_val = 5'b00000;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks += 2;
            if (u_if.in_rdy !== 5'b00000) begin failures++; $display("FAIL idle_in_rdy got=%b exp=00000", u_if.in_rdy); end
            if (u_if.out_val !== 1'b0) begin failures++; $display("FAIL idle_out_val got=%b exp=0", u_if.out_val); end
        end
    endtask

    // Pops one expected word and compares it against the buffer after an edge.
    task automatic expect_word(input string name);
        exp_t e;
        bit   ok;
        sb_pop(e, ok);
        checks += 3;
        if (!ok) begin failures++; $display("FAIL %s scoreboard empty", name); end
        if (u_if.out_val !== 1'b1) begin failures++; $display("FAIL %s out_val got=%b exp=1", name, u_if.out_val); end
        if (u_if.out !== e.data) begin failures++; $display("FAIL %s out got=%h exp=%h", name, u_if.out, e.data); end
        if (u_if.out_src !== e.src) begin failures++; $display("FAIL %s out_src got=%0d exp=%0d", name, u_if.out_src, e.src); end
    endtask

    task automatic test_single();
        set_data(4'h1, 4'h2, 4'hA, 4'h4, 4'h5);
        u_if.in_val  = 5'b00100;
        u_if.out_rdy = 1'b1;
        #1;
        checks++;
        if (u_if.in_rdy !== 5'b00100) begin failures++; $display("FAIL single_in_rdy got=%b exp=00100", u_if.in_rdy); end
        sb_q.push_back('{src: 3'd2, data: 4'hA});
        @(posedge clk); #1;
        expect_word("single");
        u_if.in_val = 5'b00000;
        @(posedge clk); #1;
        checks += 2;
        if (u_if.out_val !== 1'b0) begin failures++; $display("FAIL drain_out_val got=%b exp=0", u_if.out_val); end
        if (u_if.out !== 4'hA) begin failures++; $display("FAIL drain_out_hold got=%h exp=a", u_if.out); end
        set_data(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        u_if.in_val = 5'b11111;
        #1;
        checks++;
        if (u_if.in_rdy !== 5'b01000) begin failures++; $display("FAIL ptr3_in_rdy got=%b exp=01000", u_if.in_rdy); end
        sb_q.push_back('{src: 3'd3, data: 4'h4});
        @(posedge clk); #1;
        expect_word("ptr3");
        #1;
        checks++;
        if (u_if.in_rdy !== 5'b10000) begin failures++; $display("FAIL ptr4_in_rdy got=%b exp=10000", u_if.in_rdy); end
        sb_q.push_back('{src: 3'd4, data: 4'h5});
        @(posedge clk); #1;
        expect_word("ptr4");
        u_if.in_val = 5'b00000;
    endtask

    task automatic test_back_to_back();
        sel_t  exp_src [6];
        data_t exp_dat [6];
        exp_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        exp_dat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h1};
        u_if.in_val  = 5'b11111;
        u_if.out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (u_if.in_rdy !== (5'b00001 << exp_src[i]))
                begin failures++; $display("FAIL b2b_in_rdy[%0d] got=%b exp=%b", i, u_if.in_rdy, 5'b00001 << exp_src[i]); end
            sb_q.push_back('{src: exp_src[i], data: exp_dat[i]});
            @(posedge clk); #1;
            expect_word("b2b");
        end
    endtask

    task automatic test_backpressure();
        u_if.out_rdy = 1'b0;
        u_if.in_val  = 5'b00011;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (u_if.in_rdy !== 5'b00000) begin failures++; $display("FAIL bp_in_rdy got=%b exp=00000", u_if.in_rdy); end
            @(posedge clk); #1;
            checks += 3;
            if (u_if.out !== 4'h1) begin failures++; $display("FAIL bp_out got=%h exp=1", u_if.out); end
            if (u_if.out_src !== 3'd0) begin failures++; $display("FAIL bp_out_src got=%0d exp=0", u_if.out_src); end
            if (u_if.out_val !== 1'b1) begin failures++; $display("FAIL bp_out_val got=%b exp=1", u_if.out_val); end
        end
        u_if.out_rdy = 1'b1;
        #1;
        checks++;
        if (u_if.in_rdy !== 5'b00010) begin failures++; $display("FAIL bp_release_in_rdy got=%b exp=00010", u_if.in_rdy); end
        sb_q.push_back('{src: 3'd1, data: 4'h2});
        @(posedge clk); #1;
        expect_word("bp_release");
        u_if.in_val = 5'b00000;
    endtask

    task automatic test_wrap();
        logic [4:0] vals [3];
        logic [4:0] rdys [3];
        sel_t       srcs [3];
        data_t      dats [3];
        vals = '{5'b01000, 5'b00010, 5'b00111};
        rdys = '{5'b01000, 5'b00010, 5'b00100};
        srcs = '{3'd3, 3'd1, 3'd2};
        dats = '{4'h4, 4'h2, 4'h3};
        for (int i = 0; i < 3; i++) begin
            u_if.in_val = vals[i];
            #1;
            checks++;
            if (u_if.in_rdy !== rdys[i]) begin failures++; $display("FAIL wrap_in_rdy[%0d] got=%b exp=%b", i, u_if.in_rdy, rdys[i]); end
            sb_q.push_back('{src: srcs[i], data: dats[i]});
            @(posedge clk); #1;
            expect_word("wrap");
        end
        u_if.in_val = 5'b00000;
    endtask

    task automatic test_async_reset();
        u_if.out_rdy = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (u_if.out_val !== 1'b1) begin failures++; $display("FAIL arst_pre_out_val got=%b exp=1", u_if.out_val); end
        #2 reset = 1'b0;
        u_if.in_val = 5'b11111;
        #1;
        checks += 4;
        if (u_if.out_val !== 1'b0) begin failures++; $display("FAIL arst_out_val got=%b exp=0", u_if.out_val); end
        if (u_if.out !== 4'h0) begin failures++; $display("FAIL arst_out got=%h exp=0", u_if.out); end
        if (u_if.out_src !== 3'd0) begin failures++; $display("FAIL arst_out_src got=%0d exp=0", u_if.out_src); end
        if (u_if.in_rdy !== 5'b00000) begin failures++; $display("FAIL arst_in_rdy got=%b exp=00000", u_if.in_rdy); end
        @(posedge clk); #1;
        reset = 1'b1;
        u_if.out_rdy = 1'b1;
        #1;
        checks++;
        if (u_if.in_rdy !== 5'b00001) begin failures++; $display("FAIL arst_first_in_rdy got=%b exp=00001", u_if.in_rdy); end
        sb_q.push_back('{src: 3'd0, data: 4'h1});
        @(posedge clk); #1;
        expect_word("arst_first");
        u_if.in_val = 5'b00000;
    endtask

    initial begin
        u_if.in_val  = '0;
        u_if.out_rdy = 1'b0;
        set_data(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_rr_arb_4b_5to1.md
# seq_rr_arb_4b_5to1

Round-robin arbiter and output stage placed directly upstream of the 4-bit 5-to-1 mux datapath. It accepts up to five 4-bit requesters over valid/ready handshakes and chooses one per cycle. It drives the chosen index as the 3-bit select to an internal 5-to-1 mux and registers the selected data into a single-entry output buffer with its own valid/ready handshake. Select values 5–7 are never generated.

## Interface

Parameters: none. Widths are fixed at 4-bit data, 5 inputs and 3-bit select.

Ports:
- clk      input   1  clock; all state updates on the rising edge
- reset    input   1  asynchronous, active-low reset; one clock, and reset is asynchronous and active-low
- in_val   input   5  per-requester valid; bit i belongs to in<i>
- in_rdy   output  5  per-requester ready; at most one bit is high in any cycle
- in0..in4 input   4  requester data
- out_val  output  1  output buffer holds valid data
- out_rdy  input   1  consumer ready
- out      output  4  buffered data
- out_src  output  3  index (0–4) of the requester that produced out

## Operation

- State:
  - ptr (3 bits): round-robin priority pointer, values 0–4.
  - Output buffer registers: out_val, out, out_src.
- Grant:
  - Scan in_val starting at index ptr, upward modulo 5. The first set bit is the grant g.
  - If no in_val bit is set, there is no grant.
- can_accept = !out_val | out_rdy. The buffer is empty, or it is draining in this same cycle.
- in_rdy[g] = can_accept & reset deasserted. All other in_rdy bits are 0.
  - in_rdy depends combinationally on in_val, out_val, out_rdy and ptr.
- Accept occurs when in_val[g] & in_rdy[g]. On that edge:
  - out <= in<g>
  - out_src <= g
  - out_val <= 1
  - ptr <= (g == 4) ? 0 : g + 1
- Drain without accept (out_val & out_rdy, no grant): out_val <= 0. out and out_src hold their values.
- Hold (out_val & !out_rdy): out, out_src and out_val are unchanged. All in_rdy are 0. ptr is unchanged.
- ptr changes only on an accept.
- The internal select to the mux is always g, or 0 when there is no grant. It never takes values 5–7.

## Timing

- Reset values:
  - out_val = 0, out = 0, out_src = 0, ptr = 0.
  - in_rdy = 0 while reset is low.
- Reset mid-operation clears state immediately, without waiting for clk. Any buffered word is discarded. Accept is blocked until the first rising edge after reset goes high.
- Latency: data accepted on edge N appears on out, with out_val = 1, immediately after edge N. That is 1 cycle.
- Throughput: one word per cycle while out_rdy stays high. A simultaneous drain and accept on the same edge is legal and required.
- Wrap-around: a grant to index 4 sets ptr to 0.
- A requester that holds in_val high without being granted sees in_rdy = 0. Its data must remain stable. Starvation bound: it waits at most 4 accepts.

## Structure

- Shared package `seq_arb_pkg`:
  - NUM_IN = 5
  - DATA_W = 4
  - SEL_W = 3
  - typedef sel_t (logic [2:0])
  - typedef data_t (logic [3:0])
- One sub-module, `mux_4b_5to1`: purely combinational. sel 0–4 selects in0–in4; sel 5–7 yields 0.
- Grant logic, the ptr register and the output buffer stay in the top module.

## Test plan

- Reset sequence: hold reset low for 2 cycles.
  - Required: out_val = 0, out = 0, out_src = 0 and in_rdy = 0 throughout.
  - After release with in_val = 0: in_rdy stays 0 and out_val stays 0.
- Single requester: in_val = 5'b00100, in2 = 4'hA, out_rdy = 1.
  - Required: in_rdy = 5'b00100, then next cycle out = A, out_src = 2, out_val = 1.
  - Afterwards ptr = 3, observable through the next grant order.
- Full contention: in_val = 5'b11111, in0..in4 = 1,2,3,4,5, out_rdy = 1 for 6 cycles.
  - Required: out_src sequence is 0,1,2,3,4,0 and out is 1,2,3,4,5,1.
- Backpressure: buffer full, out_rdy = 0 for 3 cycles with in_val = 5'b00011.
  - Required: in_rdy = 0 and out stable for those 3 cycles.
  - When out_rdy rises, the drain and the next accept happen on the same edge, and out_val stays 1.
- Wrap and skip: ptr = 4 with in_val = 5'b00010.
  - Required: grant 1, out_src = 1, then ptr = 2.
- Async reset mid-stream: assert reset between edges while out_val = 1.
  - Required: out_val falls immediately, before the next edge.
  - After release, the first grant follows ptr = 0 order.
